// File: rtl/ax_4kb_splitter_pkg.sv
// Shared definitions for the AXI address-channel 4 KB splitter and its info FIFO.
package ax_4kb_splitter_pkg;

    localparam int BIT_OFFSET_4KB = 12;
    localparam int INFO_FLAG_W    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } split_state_e;

    function automatic int info_width(input int id_width);
        return id_width + INFO_FLAG_W;
    endfunction

endpackage

// File: rtl/ax_split_info_fifo.sv
// Small synchronous FIFO holding {ID, split} records for the response merger.
module ax_split_info_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Overflow and underflow requests are dropped rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= din_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ax_4kb_splitter.sv
// AW/AR stage that reissues an INCR burst as one request, or as two when it crosses a 4 KB page.
module ax_4kb_splitter
    import ax_4kb_splitter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 5,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3,
    parameter int INFO_DEPTH = 4
) (
    input  logic                  ACLK_i,
    input  logic                  ARESETn_i,
    input  logic [ID_WIDTH-1:0]   AxID_i,
    input  logic [ADDR_WIDTH-1:0] AxADDR_i,
    input  logic [LEN_WIDTH-1:0]  AxLEN_i,
    input  logic [SIZE_WIDTH-1:0] AxSIZE_i,
    input  logic                  AxVALID_i,
    output logic                  AxREADY_o,
    output logic [ID_WIDTH-1:0]   AxID_o,
    output logic [ADDR_WIDTH-1:0] AxADDR_o,
    output logic [LEN_WIDTH-1:0]  AxLEN_o,
    output logic [SIZE_WIDTH-1:0] AxSIZE_o,
    output logic                  AxVALID_o,
    input  logic                  AxREADY_i,
    output logic [ID_WIDTH-1:0]   info_id_o,
    output logic                  info_split_o,
    output logic                  info_valid_o,
    input  logic                  info_ready_i
);

    localparam int BYTES_W = LEN_WIDTH + 1 + 2**SIZE_WIDTH - 1;
    localparam int INFO_W  = info_width(ID_WIDTH);
    localparam int CNT_W   = $clog2(INFO_DEPTH) + 1;
    localparam int PAGE_W  = ADDR_WIDTH - BIT_OFFSET_4KB;
    localparam logic [BIT_OFFSET_4KB:0] PAGE_SIZE = (BIT_OFFSET_4KB+1)'(1) << BIT_OFFSET_4KB;

    split_state_e            state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [SIZE_WIDTH-1:0]   size_q, size_d;
    logic                    cross_q, cross_d;
    logic [ADDR_WIDTH-1:0]   page_next_q, page_next_d;
    logic [LEN_WIDTH-1:0]    len_b_q, len_b_d;

    logic [BIT_OFFSET_4KB-1:0] a_lo;
    logic [BYTES_W-1:0]        bytes;
    logic [BYTES_W:0]          end_off;
    logic                      cross_c;
    logic [BIT_OFFSET_4KB:0]   beats_a;
    logic [LEN_WIDTH-1:0]      len_a;
    logic [LEN_WIDTH-1:0]      len_b;
    logic [ADDR_WIDTH-1:0]     page_next;

    logic                      push;
    logic                      pop;
    logic [INFO_W-1:0]         info_head;
    logic                      info_full;
    logic                      info_empty;
    logic [CNT_W-1:0]          info_count;
    logic [CNT_W-1:0]          count_next;

    // Split geometry of the request currently on the upstream port; only used at capture.
    always_comb begin
        a_lo      = AxADDR_i[BIT_OFFSET_4KB-1:0]
                    & ~((BIT_OFFSET_4KB'(1) << AxSIZE_i) - BIT_OFFSET_4KB'(1));
        bytes     = BYTES_W'({1'b0, AxLEN_i} + (LEN_WIDTH+1)'(1)) << AxSIZE_i;
        end_off   = (BYTES_W+1)'(a_lo) + (BYTES_W+1)'(bytes);
        cross_c   = end_off > (BYTES_W+1)'(PAGE_SIZE);
        beats_a   = (PAGE_SIZE - {1'b0, a_lo}) >> AxSIZE_i;
        len_a     = LEN_WIDTH'(beats_a - (BIT_OFFSET_4KB+1)'(1));
        len_b     = AxLEN_i - LEN_WIDTH'(beats_a);
        page_next = {AxADDR_i[ADDR_WIDTH-1:BIT_OFFSET_4KB] + PAGE_W'(1), {BIT_OFFSET_4KB{1'b0}}};
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        cross_d     = cross_q;
        page_next_d = page_next_q;
        len_b_d     = len_b_q;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (AxVALID_i && ready_q && !info_full) begin
                    push        = 1'b1;
                    state_d     = SEND_A;
                    valid_d     = 1'b1;
                    id_d        = AxID_i;
                    addr_d      = AxADDR_i;
                    len_d       = cross_c ? len_a : AxLEN_i;
                    size_d      = AxSIZE_i;
                    cross_d     = cross_c;
                    page_next_d = page_next;
                    len_b_d     = len_b;
                end
            end
            SEND_A: begin
                if (AxREADY_i) begin
                    if (cross_q) begin
                        state_d = SEND_B;
                        addr_d  = page_next_q;
                        len_d   = len_b_q;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            SEND_B: begin
                if (AxREADY_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Ready is registered, so it looks at the occupancy after this edge.
        count_next = info_count + CNT_W'(push) - CNT_W'(pop);
        ready_d    = (state_d == IDLE) && (count_next < CNT_W'(INFO_DEPTH));
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            cross_q     <= 1'b0;
            page_next_q <= '0;
            len_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            cross_q     <= cross_d;
            page_next_q <= page_next_d;
            len_b_q     <= len_b_d;
        end
    end

    assign AxREADY_o = ready_q;
    assign AxVALID_o = valid_q;
    assign AxID_o    = id_q;
    assign AxADDR_o  = addr_q;
    assign AxLEN_o   = len_q;
    assign AxSIZE_o  = size_q;

    assign pop = !info_empty && info_ready_i;

    ax_split_info_fifo #(
        .WIDTH (INFO_W),
        .DEPTH (INFO_DEPTH)
    ) u_info_fifo (
        .clk     (ACLK_i),
        .rst_n   (ARESETn_i),
        .push_i  (push),
        .din_i   ({AxID_i, cross_c}),
        .pop_i   (pop),
        .dout_o  (info_head),
        .full_o  (info_full),
        .empty_o (info_empty),
        .count_o (info_count)
    );

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign info_valid_o               = !info_empty;
    assign {info_id_o, info_split_o}  = info_empty ? '0 : info_head;

endmodule
